// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO stream reader and its holding queue.
package fifo_stream_pkg;

   localparam int PKT_CNT_W = 16;
   localparam int Q_DEPTH   = 3;

   // Advance a ring pointer, wrapping back to zero at depth.
   function automatic int unsigned ring_next(input int unsigned ptr, input int unsigned depth);
      return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/stream_regq.sv
// Small register-based FIFO queue with head/tail ring pointers and an occupancy count.
// A push and a pop in the same cycle are legal even when full.
module stream_regq
   import fifo_stream_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int Depth     = Q_DEPTH
) (
   input  logic                         clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  logic [DataWidth-1:0]         i_push_data,
   input  logic                         i_pop,
   output logic [DataWidth-1:0]         o_head_data,
   output logic [$clog2(Depth+1)-1:0]   o_occ
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int OccW = $clog2(Depth + 1);

   typedef logic [PtrW-1:0] ptr_t;

   logic [DataWidth-1:0] mem_q [Depth];
   ptr_t                 head_q, head_d;
   ptr_t                 tail_q, tail_d;
   logic [OccW-1:0]      occ_q, occ_d;
   logic                 do_pop;
   logic                 do_push;

   assign do_pop      = i_pop && (occ_q != '0);
   assign do_push     = i_push && ((occ_q != OccW'(Depth)) || do_pop);
   assign o_head_data = mem_q[head_q];
   assign o_occ       = occ_q;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (do_push) tail_d = ptr_t'(ring_next(32'(tail_q), Depth));
      if (do_pop)  head_d = ptr_t'(ring_next(32'(head_q), Depth));
      occ_d = occ_q + OccW'(do_push) - OccW'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= i_push_data;
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle read latency into a valid/ready stream,
// absorbing the latency in a 3-entry holding queue and framing packets of PacketLen beats.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int PacketLen = 16
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_fifo_empty,
   input  logic [DataWidth-1:0] i_fifo_data,
   output logic                 o_fifo_read,
   output logic                 o_valid,
   output logic [DataWidth-1:0] o_data,
   output logic                 o_last,
   input  logic                 i_ready,
   output logic [PKT_CNT_W-1:0] o_pkt_count
);

   localparam int BeatW = (PacketLen > 1) ? $clog2(PacketLen) : 1;
   localparam int OccW  = $clog2(Q_DEPTH + 1);

   typedef logic [BeatW-1:0] beat_cnt_t;

   localparam beat_cnt_t LastBeat = beat_cnt_t'(PacketLen - 1);

   logic                 inflight_q, inflight_d;
   beat_cnt_t            beat_q, beat_d;
   logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
   logic [OccW-1:0]      occ;
   logic [OccW:0]        committed;
   logic                 pop;

   // Words already queued plus the one still in the FIFO's read pipeline; never looks at i_ready.
   assign committed   = {1'b0, occ} + {{OccW{1'b0}}, inflight_q};
   assign o_fifo_read = i_rst_n && !i_fifo_empty && (committed < (OccW + 1)'(Q_DEPTH));

   assign o_valid     = (occ != '0);
   assign o_last      = o_valid && (beat_q == LastBeat);
   assign pop         = o_valid && i_ready;
   assign o_pkt_count = pkt_q;

   stream_regq #(
      .DataWidth (DataWidth),
      .Depth     (Q_DEPTH)
   ) u_queue (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_push      (inflight_q),
      .i_push_data (i_fifo_data),
      .i_pop       (pop),
      .o_head_data (o_data),
      .o_occ       (occ)
   );

   always_comb begin
      inflight_d = o_fifo_read;
      beat_d     = beat_q;
      pkt_d      = pkt_q;
      if (pop) begin
         beat_d = (beat_q == LastBeat) ? '0 : beat_q + beat_cnt_t'(1);
         if (o_last) pkt_d = pkt_q + PKT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight_q <= 1'b0;
         beat_q     <= '0;
         pkt_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a behavioural FIFO feeds three reader instances (PacketLen 16, 4, 1);
// a scoreboard of pushed words plus a small occupancy model predicts every output.
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst_n;
   logic        i_fifo_empty;
   logic [31:0] i_fifo_data;
   logic        i_ready;

   logic        rd16, v16, l16;
   logic [31:0] d16;
   logic [15:0] pc16;
   logic        rd4, v4, l4;
   logic [31:0] d4;
   logic [15:0] pc4;
   logic        rd1, v1, l1;
   logic [31:0] d1;
   logic [15:0] pc1;

   logic [31:0] fifo_q[$];
   logic [31:0] sb[$];
   int          exp_occ;
   int          exp_infl;
   int          pops;
   int          dut_reads;
   int          checks;
   int          failures;

   fifo_stream_reader #(.DataWidth(32), .PacketLen(16)) u_dut16 (
      .clk(clk), .i_rst_n(rst_n), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
      .o_fifo_read(rd16), .o_valid(v16), .o_data(d16), .o_last(l16),
      .i_ready(i_ready), .o_pkt_count(pc16)
   );

   fifo_stream_reader #(.DataWidth(32), .PacketLen(4)) u_dut4 (
      .clk(clk), .i_rst_n(rst_n), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
      .o_fifo_read(rd4), .o_valid(v4), .o_data(d4), .o_last(l4),
      .i_ready(i_ready), .o_pkt_count(pc4)
   );

   fifo_stream_reader #(.DataWidth(32), .PacketLen(1)) u_dut1 (
      .clk(clk), .i_rst_n(rst_n), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
      .o_fifo_read(rd1), .o_valid(v1), .o_data(d1), .o_last(l1),
      .i_ready(i_ready), .o_pkt_count(pc1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      sb.push_back(w);
      i_fifo_empty = 1'b0;
   endtask

   // One clock: compare at the falling edge, then advance the model and the FIFO just after the rising edge.
   task automatic step();
      logic exp_rd;
      logic exp_pop;
      @(negedge clk);
      exp_rd = !i_fifo_empty && ((exp_occ + exp_infl) < 3);
      check("fifo_read16", rd16, exp_rd);
      check("fifo_read4", rd4, exp_rd);
      check("fifo_read1", rd1, exp_rd);
      check("read_on_empty", rd16 & i_fifo_empty, 0);
      check("valid16", v16, exp_occ != 0);
      check("valid4", v4, exp_occ != 0);
      check("valid1", v1, exp_occ != 0);
      if (exp_occ != 0) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            check("data16", d16, sb[0]);
            check("data4", d4, sb[0]);
            check("data1", d1, sb[0]);
         end
         check("last16", l16, (pops % 16) == 15);
         check("last4", l4, (pops % 4) == 3);
         check("last1", l1, 1);
      end else begin
         check("last_idle16", l16, 0);
      end
      check("pkt16", pc16, pops / 16);
      check("pkt4", pc4, pops / 4);
      check("pkt1", pc1, pops);
      if (rd16) dut_reads++;
      exp_pop = (exp_occ != 0) && i_ready;
      @(posedge clk);
      #1;
      if (exp_pop) begin
         if (sb.size() != 0) void'(sb.pop_front());
         pops++;
      end
      exp_occ  = exp_occ + exp_infl - (exp_pop ? 1 : 0);
      exp_infl = exp_rd ? 1 : 0;
      if (exp_rd && fifo_q.size() != 0) i_fifo_data = fifo_q.pop_front();
      i_fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0) && (n < budget)) begin
         step();
         n++;
      end
      check(tag, sb.size(), 0);
   endtask

   // Asserts reset a few ns after a rising edge (mid-cycle), checks the outputs collapse at once, then realigns.
   task automatic mid_cycle_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_read16", rd16, 0);
      check("rst_read4", rd4, 0);
      check("rst_valid16", v16, 0);
      check("rst_valid4", v4, 0);
      check("rst_valid1", v1, 0);
      check("rst_last4", l4, 0);
      check("rst_last1", l1, 0);
      check("rst_pkt16", pc16, 0);
      check("rst_pkt4", pc4, 0);
      check("rst_pkt1", pc1, 0);
      fifo_q.delete();
      sb.delete();
      i_fifo_empty = 1'b1;
      i_fifo_data  = '0;
      exp_occ  = 0;
      exp_infl = 0;
      pops     = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int r0;
      checks       = 0;
      failures     = 0;
      exp_occ      = 0;
      exp_infl     = 0;
      pops         = 0;
      dut_reads    = 0;
      rst_n        = 1'b0;
      i_ready      = 1'b0;
      i_fifo_empty = 1'b1;
      i_fifo_data  = '0;

      // Power-on reset, with a word already waiting so the read strobe is held off only by reset.
      repeat (2) @(posedge clk);
      #1;
      i_fifo_empty = 1'b0;
      #1;
      check("por_read16", rd16, 0);
      check("por_valid16", v16, 0);
      check("por_last1", l1, 0);
      check("por_pkt16", pc16, 0);
      i_fifo_empty = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back stream of four words with the consumer always ready.
      i_ready = 1'b1;
      r0 = dut_reads;
      for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
      drain("t1_drain", 20);
      check("t1_reads", dut_reads - r0, 4);

      // Stalled consumer: only three reads may be issued; the head word holds.
      i_ready = 1'b0;
      r0 = dut_reads;
      for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
      repeat (8) step();
      check("t2_stall_reads", dut_reads - r0, 3);
      check("t2_head", d16, 32'h100);
      check("t2_valid", v16, 1);
      i_ready = 1'b1;
      drain("t2_drain", 40);
      check("t2_total_reads", dut_reads - r0, 10);
      check("t2_fifo_empty", fifo_q.size(), 0);

      // Twelve words under random back-pressure; framing counted from a fresh reset.
      mid_cycle_reset();
      for (int i = 0; i < 12; i++) push_word(32'h200 + 32'(i));
      begin
         int n;
         n = 0;
         while ((sb.size() != 0) && (n < 200)) begin
            i_ready = 1'($urandom_range(0, 1));
            step();
            n++;
         end
      end
      check("t3_drain", sb.size(), 0);
      check("t3_pkt4", pc4, 3);
      check("t3_pkt1", pc1, 12);
      check("t3_pkt16", pc16, 0);

      // FIFO runs dry mid-stream, then refills.
      mid_cycle_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i));
      repeat (8) step();
      check("t4_idle_valid", v16, 0);
      for (int i = 0; i < 2; i++) push_word(32'h310 + 32'(i));
      drain("t4_drain", 20);

      // Single-beat packets.
      mid_cycle_reset();
      for (int i = 0; i < 5; i++) push_word(32'h400 + 32'(i));
      drain("t5_drain", 20);
      step();
      check("t5_pkt1", pc1, 5);

      // Reset mid-cycle with two words queued and one in flight, then a clean restart.
      i_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(32'h500 + 32'(i));
      repeat (3) step();
      check("t6_occ_valid", v1, 1);
      mid_cycle_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_word(32'h600 + 32'(i));
      drain("t6_restart_drain", 20);
      step();
      check("t6_restart_pkt4", pc4, 1);
      check("t6_restart_pkt1", pc1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
